// File: rtl/psd_pkg.sv
// Shared types, default widths and helper functions for the phase-sensitive detector.
package psd_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ACC_W_DEF  = 48;
    localparam int EXT_W      = 64;  // widest accumulator the helpers support

    typedef enum logic {IDLE, ACCUM} state_t;

    // Sign-extend the low w bits of x to EXT_W bits.
    function automatic logic signed [EXT_W-1:0] sext(input logic [EXT_W-1:0] x, input int unsigned w);
        logic signed [EXT_W-1:0] r;
        r = x << (EXT_W - w);
        return r >>> (EXT_W - w);
    endfunction

    function automatic logic [EXT_W-1:0] acc_max(input int unsigned w);
        return (EXT_W'(1) << (w - 1)) - EXT_W'(1);
    endfunction

    function automatic logic [EXT_W-1:0] acc_min(input int unsigned w);
        return ~acc_max(w);
    endfunction

endpackage

// File: rtl/psd_demod_if.sv
// Sample/reference inputs and I/Q result outputs of the lock-in demodulator.
interface psd_demod_if import psd_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
);
    logic signed [DATA_W-1:0] i_adc_data;
    logic signed [DATA_W-1:0] i_ref_sin;
    logic signed [DATA_W-1:0] i_ref_cos;
    logic                     i_psd_flag;
    logic signed [ACC_W-1:0]  o_I;
    logic signed [ACC_W-1:0]  o_Q;
    logic [15:0]              o_n_samples;
    logic                     o_valid;
    logic                     o_ovf;
    logic                     o_timeout;

    modport master (
        output i_adc_data, i_ref_sin, i_ref_cos, i_psd_flag,
        input  o_I, o_Q, o_n_samples, o_valid, o_ovf, o_timeout
    );

    modport slave (
        input  i_adc_data, i_ref_sin, i_ref_cos, i_psd_flag,
        output o_I, o_Q, o_n_samples, o_valid, o_ovf, o_timeout
    );
endinterface

// File: rtl/psd_mac_sat.sv
// Registered signed multiply followed by a clearable, loadable, saturating accumulator.
module psd_mac_sat import psd_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic                     clear,
    input  logic                     load,
    input  logic                     accum,
    output logic signed [ACC_W-1:0]  acc,
    output logic                     ovf
);
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(acc_max(ACC_W));
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(acc_min(ACC_W));

    logic signed [2*DATA_W-1:0] prod_p1;
    logic signed [ACC_W-1:0]    ext_p1;
    logic signed [ACC_W-1:0]    sum_p1;
    logic                       ovf_raw;
    logic signed [ACC_W-1:0]    acc_p2;

    // Returns {overflow, clamped sum}.
    function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] x,
                                               input logic signed [ACC_W-1:0] y);
        logic signed [ACC_W:0] s;
        s = {x[ACC_W-1], x} + {y[ACC_W-1], y};
        if (s[ACC_W] != s[ACC_W-1])
            return {1'b1, (s[ACC_W] ? ACC_MIN : ACC_MAX)};
        return {1'b0, s[ACC_W-1:0]};
    endfunction

    assign ext_p1 = ACC_W'(sext(EXT_W'($unsigned(prod_p1)), 2 * DATA_W));

    always_comb begin
        {ovf_raw, sum_p1} = sat_add(acc_p2, ext_p1);
    end

    // S2: product register; S3: accumulator
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod_p1 <= '0;
            acc_p2  <= '0;
        end else begin
            prod_p1 <= (2*DATA_W)'(a) * (2*DATA_W)'(b);
            if (clear)
                acc_p2 <= '0;
            else if (load)
                acc_p2 <= ext_p1;
            else if (accum)
                acc_p2 <= sum_p1;
        end
    end

    assign acc = acc_p2;
    assign ovf = accum & ovf_raw;
endmodule

// File: rtl/psd_demod.sv
// Lock-in demodulator: multiplies ADC samples by the NCO sin/cos pair and sums I/Q per strobe window.
module psd_demod import psd_pkg::*; #(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int DEC_N   = 1,
    parameter int MAX_GAP = 1024
) (
    input logic        i_clk_250M,
    input logic        i_rst_n,
    psd_demod_if.slave bus
);
    localparam int               GAP_W    = $clog2(MAX_GAP + 1);
    localparam logic [7:0]       WIN_LAST = 8'(DEC_N - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MAX_GAP - 1);

    logic signed [DATA_W-1:0] adc_p0, sin_p0, cos_p0;
    logic                     flag_p0, flag_p1;
    state_t                   state, state_nxt;
    logic                     load, accum, clear, close, expire, gap_hit;
    logic [15:0]              n_p2;
    logic [7:0]               win_p2;
    logic [GAP_W-1:0]         gap_p2;
    logic                     ovf_sticky, ovf_i, ovf_q;
    logic signed [ACC_W-1:0]  acc_i_p2, acc_q_p2, res_i_p2, res_q_p2;
    logic [15:0]              res_n_p2;
    logic                     res_ovf_p2, vld_p2, timeout;

    // S1: input capture; S2: flag delayed to line up with the products
    always_ff @(posedge i_clk_250M) begin
        if (!i_rst_n) begin
            adc_p0  <= '0;
            sin_p0  <= '0;
            cos_p0  <= '0;
            flag_p0 <= 1'b0;
            flag_p1 <= 1'b0;
        end else begin
            adc_p0  <= bus.i_adc_data;
            sin_p0  <= bus.i_ref_sin;
            cos_p0  <= bus.i_ref_cos;
            flag_p0 <= bus.i_psd_flag;
            flag_p1 <= flag_p0;
        end
    end

    psd_mac_sat #(.DATA_W(DATA_W), .ACC_W(ACC_W)) mac_i (
        .clk(i_clk_250M), .rst_n(i_rst_n), .a(adc_p0), .b(sin_p0),
        .clear(clear), .load(load), .accum(accum), .acc(acc_i_p2), .ovf(ovf_i)
    );

    psd_mac_sat #(.DATA_W(DATA_W), .ACC_W(ACC_W)) mac_q (
        .clk(i_clk_250M), .rst_n(i_rst_n), .a(adc_p0), .b(cos_p0),
        .clear(clear), .load(load), .accum(accum), .acc(acc_q_p2), .ovf(ovf_q)
    );

    assign gap_hit = (gap_p2 == GAP_LAST);

    always_ff @(posedge i_clk_250M) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (flag_p1) state_nxt = ACCUM;
            ACCUM:   if (!flag_p1 && gap_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load   = 1'b0;
        accum  = 1'b0;
        clear  = 1'b0;
        close  = 1'b0;
        expire = 1'b0;
        case (state)
            IDLE: begin
                if (flag_p1) load  = 1'b1;
                else         clear = 1'b1;
            end
            ACCUM: begin
                if (flag_p1) begin
                    if (win_p2 == WIN_LAST) begin
                        close = 1'b1;
                        load  = 1'b1;
                    end else begin
                        accum = 1'b1;
                    end
                end else if (gap_hit) begin
                    expire = 1'b1;
                    clear  = 1'b1;
                end else begin
                    accum = 1'b1;
                end
            end
            default: clear = 1'b1;
        endcase
    end

    // S3: window counters and result registers
    always_ff @(posedge i_clk_250M) begin
        if (!i_rst_n) begin
            n_p2       <= '0;
            win_p2     <= '0;
            gap_p2     <= '0;
            ovf_sticky <= 1'b0;
            res_i_p2   <= '0;
            res_q_p2   <= '0;
            res_n_p2   <= '0;
            res_ovf_p2 <= 1'b0;
            vld_p2     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            vld_p2 <= close;
            if (close) begin
                res_i_p2   <= acc_i_p2;
                res_q_p2   <= acc_q_p2;
                res_n_p2   <= n_p2;
                res_ovf_p2 <= ovf_sticky;
            end
            if (expire)
                timeout <= 1'b1;
            if (load) begin
                n_p2       <= 16'd1;
                win_p2     <= '0;
                gap_p2     <= '0;
                ovf_sticky <= 1'b0;
            end else if (accum) begin
                n_p2       <= (n_p2 == 16'hFFFF) ? n_p2 : n_p2 + 16'd1;
                ovf_sticky <= ovf_sticky | ovf_i | ovf_q;
                if (flag_p1) begin
                    win_p2 <= win_p2 + 8'd1;
                    gap_p2 <= '0;
                end else begin
                    gap_p2 <= gap_p2 + GAP_W'(1);
                end
            end else begin
                n_p2       <= '0;
                win_p2     <= '0;
                gap_p2     <= '0;
                ovf_sticky <= 1'b0;
            end
        end
    end

    assign bus.o_I         = res_i_p2;
    assign bus.o_Q         = res_q_p2;
    assign bus.o_n_samples = res_n_p2;
    assign bus.o_ovf       = res_ovf_p2;
    assign bus.o_valid     = vld_p2;
    assign bus.o_timeout   = timeout;
endmodule

// File: tb/tb_psd_demod.sv
// Scoreboard bench for psd_demod: three instances (default, ACC_W=36, DEC_N=4) with directed windows.
module tb_psd_demod;
    typedef struct {
        longint i;
        longint q;
        int     n;
        bit     ovf;
        int     cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   flag_cyc = 0;
    int   tgt;

    logic signed [15:0] adc[3];
    logic signed [15:0] sn[3];
    logic signed [15:0] cs[3];
    logic               flg[3];
    exp_t               sbq[3][$];

    always #2 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    psd_demod_if #(.DATA_W(16), .ACC_W(48)) bus0 ();
    psd_demod_if #(.DATA_W(16), .ACC_W(36)) bus1 ();
    psd_demod_if #(.DATA_W(16), .ACC_W(48)) bus2 ();

    assign bus0.i_adc_data = adc[0];
    assign bus0.i_ref_sin  = sn[0];
    assign bus0.i_ref_cos  = cs[0];
    assign bus0.i_psd_flag = flg[0];
    assign bus1.i_adc_data = adc[1];
    assign bus1.i_ref_sin  = sn[1];
    assign bus1.i_ref_cos  = cs[1];
    assign bus1.i_psd_flag = flg[1];
    assign bus2.i_adc_data = adc[2];
    assign bus2.i_ref_sin  = sn[2];
    assign bus2.i_ref_cos  = cs[2];
    assign bus2.i_psd_flag = flg[2];

    psd_demod #(.DATA_W(16), .ACC_W(48), .DEC_N(1), .MAX_GAP(1024)) dut0 (
        .i_clk_250M(clk), .i_rst_n(rst_n), .bus(bus0));
    psd_demod #(.DATA_W(16), .ACC_W(36), .DEC_N(1), .MAX_GAP(1024)) dut1 (
        .i_clk_250M(clk), .i_rst_n(rst_n), .bus(bus1));
    psd_demod #(.DATA_W(16), .ACC_W(48), .DEC_N(4), .MAX_GAP(1024)) dut2 (
        .i_clk_250M(clk), .i_rst_n(rst_n), .bus(bus2));

    function automatic void check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    task automatic mon(input int d, input logic vld, input longint ai, input longint aq,
                       input int an, input logic ao);
        exp_t e;
        if (vld !== 1'b1) return;
        if (sbq[d].size() == 0) begin
            check($sformatf("d%0d_unexpected_valid", d), longint'(vld), 0);
            return;
        end
        e = sbq[d].pop_front();
        check($sformatf("d%0d_I", d), ai, e.i);
        check($sformatf("d%0d_Q", d), aq, e.q);
        check($sformatf("d%0d_n_samples", d), an, e.n);
        check($sformatf("d%0d_ovf", d), longint'(ao), longint'(e.ovf));
        check($sformatf("d%0d_latency", d), cyc, e.cyc);
    endtask

    always @(negedge clk) begin
        mon(0, bus0.o_valid, $signed(bus0.o_I), $signed(bus0.o_Q), int'(bus0.o_n_samples), bus0.o_ovf);
        mon(1, bus1.o_valid, $signed(bus1.o_I), $signed(bus1.o_Q), int'(bus1.o_n_samples), bus1.o_ovf);
        mon(2, bus2.o_valid, $signed(bus2.o_I), $signed(bus2.o_Q), int'(bus2.o_n_samples), bus2.o_ovf);
    end

    // Strobe plus len-1 further samples; optionally push the result the strobe closes.
    task automatic window(input int d, input int a, input int s, input int c, input int len,
                          input bit push, input longint ei, input longint eq, input int en, input bit eo);
        exp_t e;
        @(negedge clk);
        adc[d] = 16'(a);
        sn[d]  = 16'(s);
        cs[d]  = 16'(c);
        flg[d] = 1'b1;
        flag_cyc = cyc;
        if (push) begin
            e = '{i: ei, q: eq, n: en, ovf: eo, cyc: cyc + 3};
            sbq[d].push_back(e);
        end
        for (int k = 1; k < len; k++) begin
            @(negedge clk);
            flg[d] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) flg[d] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_zero(input int d, input longint ai, input longint aq, input int an,
                            input logic av, input logic ao, input logic at);
        check($sformatf("d%0d_rst_I", d), ai, 0);
        check($sformatf("d%0d_rst_Q", d), aq, 0);
        check($sformatf("d%0d_rst_n_samples", d), an, 0);
        check($sformatf("d%0d_rst_valid", d), longint'(av), 0);
        check($sformatf("d%0d_rst_ovf", d), longint'(ao), 0);
        check($sformatf("d%0d_rst_timeout", d), longint'(at), 0);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            adc[d] = '0;
            sn[d]  = '0;
            cs[d]  = '0;
            flg[d] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero(0, $signed(bus0.o_I), $signed(bus0.o_Q), int'(bus0.o_n_samples), bus0.o_valid, bus0.o_ovf, bus0.o_timeout);
        chk_zero(1, $signed(bus1.o_I), $signed(bus1.o_Q), int'(bus1.o_n_samples), bus1.o_valid, bus1.o_ovf, bus1.o_timeout);
        chk_zero(2, $signed(bus2.o_I), $signed(bus2.o_Q), int'(bus2.o_n_samples), bus2.o_valid, bus2.o_ovf, bus2.o_timeout);
        rst_n = 1'b1;

        // 1000 * 16384 * 250 on I, nothing on Q
        window(0, 1000, 16384, 0, 250, 0, 0, 0, 0, 0);
        repeat (2) window(0, 1000, 16384, 0, 250, 1, 64'sd4096000000, 0, 250, 0);

        // most negative operands: 2^30 * 250 on both channels
        do_reset();
        window(0, -32768, -32768, -32768, 250, 0, 0, 0, 0, 0);
        repeat (2) window(0, -32768, -32768, -32768, 250, 1, 64'sd268435456000, 64'sd268435456000, 250, 0);

        // 36-bit accumulator clamps, then a clean window clears the overflow flag
        window(1, -32768, -32768, -32768, 250, 0, 0, 0, 0, 0);
        window(1, 1, 1, 1, 250, 1, 64'sd34359738367, 64'sd34359738367, 250, 1);
        window(1, 1, 1, 1, 250, 1, 250, 250, 250, 0);

        // four windows per result
        for (int k = 0; k < 9; k++)
            window(2, 1, 1, 0, 250, (k > 0) && (k % 4 == 0), 1000, 0, 1000, 0);

        // strobe lost after the third pulse
        do_reset();
        window(0, 1000, 16384, 0, 250, 0, 0, 0, 0, 0);
        repeat (2) window(0, 1000, 16384, 0, 250, 1, 64'sd4096000000, 0, 250, 0);
        tgt = flag_cyc + 3 + 1024;
        while (cyc < tgt - 1) @(negedge clk);
        check("d0_timeout_early", longint'(bus0.o_timeout), 0);
        @(negedge clk);
        check("d0_timeout_set", longint'(bus0.o_timeout), 1);

        // back from IDLE, then reset 100 samples into a window
        window(0, 1000, 16384, 0, 250, 0, 0, 0, 0, 0);
        window(0, 1000, 16384, 0, 100, 1, 64'sd4096000000, 0, 250, 0);
        check("d0_timeout_sticky", longint'(bus0.o_timeout), 1);
        do_reset();
        chk_zero(0, $signed(bus0.o_I), $signed(bus0.o_Q), int'(bus0.o_n_samples), bus0.o_valid, bus0.o_ovf, bus0.o_timeout);
        window(0, 1000, 16384, 0, 250, 0, 0, 0, 0, 0);
        window(0, 1000, 16384, 0, 20, 1, 64'sd4096000000, 0, 250, 0);
        repeat (10) @(negedge clk);

        for (int d = 0; d < 3; d++)
            check($sformatf("d%0d_pending_results", d), sbq[d].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
